// File: rtl/cpu_bus_pkg.sv
// Shared types and helpers for the CPU bus unit: access-size encoding,
// FSM state type, the alignment check and the byte count of an access size.
package cpu_bus_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE   = 2'd0,
        SIZE_HALF   = 2'd1,
        SIZE_WORD   = 2'd2,
        SIZE_DOUBLE = 2'd3
    } bus_size_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } bus_state_t;

    // Width of the bus wait counter; covers TIMEOUT_CYCLES up to 65535.
    localparam int TIMEOUT_CNT_W = 16;

    // True when the low address bits are a multiple of the access size.
    function automatic logic is_aligned(input logic [1:0] size, input logic [2:0] addr_low);
        logic ok;
        case (size)
            SIZE_BYTE: ok = 1'b1;
            SIZE_HALF: ok = (addr_low[0] == 1'b0);
            SIZE_WORD: ok = (addr_low[1:0] == 2'b00);
            default:   ok = (addr_low == 3'b000);
        endcase
        return ok;
    endfunction

    // Number of bytes moved by an access of the given size (1, 2, 4 or 8).
    function automatic logic [3:0] size_bytes(input logic [1:0] size);
        return 4'd1 << size;
    endfunction

endpackage

// File: rtl/bus_lane_align.sv
// Byte-lane steering between the core and the bus: strobe generation,
// replication of write data onto every lane and right-justified,
// zero-extended extraction of read data. Purely combinational.
module bus_lane_align
    import cpu_bus_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int OFFSET_W   = 2
) (
    input  logic [1:0]              size,
    input  logic [OFFSET_W-1:0]     offset,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH-1:0]   bus_rdata,
    output logic [DATA_WIDTH/8-1:0] strobe,
    output logic [DATA_WIDTH-1:0]   wdata_rep,
    output logic [DATA_WIDTH-1:0]   rdata_ext
);

    localparam int LANES = DATA_WIDTH / 8;

    logic [3:0]            nbytes;
    logic [4:0]            nb_ext;
    logic [4:0]            off_ext;
    logic [OFFSET_W-1:0]   lane_mask;
    logic [DATA_WIDTH-1:0] shifted;
    logic [7:0]            wbytes [LANES];

    assign nbytes    = size_bytes(size);
    assign nb_ext    = 5'(nbytes);
    assign off_ext   = 5'(offset);
    // Sizes are powers of two, so "lane modulo size" is a mask.
    assign lane_mask = OFFSET_W'(nbytes - 4'd1);
    assign shifted   = bus_rdata >> {offset, 3'b000};

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            localparam logic [4:0] LANE_IDX = 5'(gi);
            logic [OFFSET_W-1:0] src_lane;

            assign wbytes[gi] = wdata[gi*8 +: 8];
            // Lane gi carries source byte (gi mod size), so every window of
            // the access size holds a full copy of the write data.
            assign src_lane = LANE_IDX[OFFSET_W-1:0] & lane_mask;
            assign wdata_rep[gi*8 +: 8] = wbytes[src_lane];
            assign strobe[gi] = (LANE_IDX >= off_ext) && (LANE_IDX < off_ext + nb_ext);
            assign rdata_ext[gi*8 +: 8] = (LANE_IDX < nb_ext) ? shifted[gi*8 +: 8] : 8'h00;
        end
    endgenerate

endmodule

// File: rtl/cpu_bus_unit.sv
// CPU bus unit: accepts one core request at a time, rejects misaligned or
// unsupported sizes without touching the bus, otherwise runs a single bus
// cycle and returns a one-cycle response.
// Optional feature macro: CPU_BUS_TIMEOUT_EN enables the bus wait timeout.
module cpu_bus_unit
    import cpu_bus_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [1:0]              req_size,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    output logic                    rsp_valid,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_err,
    output logic [ADDR_WIDTH-1:0]   address,
    output logic [DATA_WIDTH-1:0]   dataOut,
    input  logic [DATA_WIDTH-1:0]   dataIn,
    output logic                    busWriteEnable,
    output logic [DATA_WIDTH/8-1:0] bus_strobe,
    output logic                    bus_valid,
    input  logic                    bus_ready
);

    localparam int LANES    = DATA_WIDTH / 8;
    localparam int OFFSET_W = $clog2(LANES);

    generate
        if (DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_bad_width
            $error("cpu_bus_unit: DATA_WIDTH must be 32 or 64");
        end
        if (ADDR_WIDTH < 3) begin : g_bad_addr
            $error("cpu_bus_unit: ADDR_WIDTH must be at least 3");
        end
        if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
            $error("cpu_bus_unit: TIMEOUT_CYCLES must be in 1..65535");
        end
    endgenerate

    bus_state_t            state_reg;
    logic                  req_ready_reg;
    logic                  rsp_valid_reg;
    logic [DATA_WIDTH-1:0] rsp_rdata_reg;
    logic                  rsp_err_reg;
    logic [ADDR_WIDTH-1:0] address_reg;
    logic [DATA_WIDTH-1:0] data_out_reg;
    logic                  write_reg;
    logic [LANES-1:0]      strobe_reg;
    logic                  bus_valid_reg;
    logic [1:0]            size_reg;
    logic [OFFSET_W-1:0]   offset_reg;

`ifdef CPU_BUS_TIMEOUT_EN
    localparam logic [TIMEOUT_CNT_W-1:0] TIMEOUT_LAST = TIMEOUT_CNT_W'(TIMEOUT_CYCLES - 1);
    logic [TIMEOUT_CNT_W-1:0] wait_count_reg;
`endif

    logic [1:0]            lane_size;
    logic [OFFSET_W-1:0]   lane_offset;
    logic [LANES-1:0]      lane_strobe;
    logic [DATA_WIDTH-1:0] lane_wdata;
    logic [DATA_WIDTH-1:0] lane_rdata;
    logic                  req_legal;

    // Lane steering follows the incoming request in IDLE and the latched request afterwards.
    always_comb begin
        lane_size   = req_size;
        lane_offset = req_addr[OFFSET_W-1:0];
        if (state_reg != ST_IDLE) begin
            lane_size   = size_reg;
            lane_offset = offset_reg;
        end
        req_legal = is_aligned(req_size, req_addr[2:0]) &&
                    !((DATA_WIDTH == 32) && (req_size == SIZE_DOUBLE));
    end

    bus_lane_align #(
        .DATA_WIDTH (DATA_WIDTH),
        .OFFSET_W   (OFFSET_W)
    ) u_lane_align (
        .size      (lane_size),
        .offset    (lane_offset),
        .wdata     (req_wdata),
        .bus_rdata (dataIn),
        .strobe    (lane_strobe),
        .wdata_rep (lane_wdata),
        .rdata_ext (lane_rdata)
    );

    // Request/bus/response FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg     <= ST_IDLE;
            req_ready_reg <= 1'b0;
            rsp_valid_reg <= 1'b0;
            rsp_rdata_reg <= '0;
            rsp_err_reg   <= 1'b0;
            address_reg   <= '0;
            data_out_reg  <= '0;
            write_reg     <= 1'b0;
            strobe_reg    <= '0;
            bus_valid_reg <= 1'b0;
            size_reg      <= '0;
            offset_reg    <= '0;
`ifdef CPU_BUS_TIMEOUT_EN
            wait_count_reg <= '0;
`endif
        end else begin
            rsp_valid_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    req_ready_reg <= 1'b1;
                    if (req_valid && req_ready_reg) begin
                        req_ready_reg <= 1'b0;
                        size_reg      <= req_size;
                        offset_reg    <= req_addr[OFFSET_W-1:0];
                        if (req_legal) begin
                            state_reg     <= ST_ACCESS;
                            bus_valid_reg <= 1'b1;
                            address_reg   <= {req_addr[ADDR_WIDTH-1:OFFSET_W], {OFFSET_W{1'b0}}};
                            data_out_reg  <= lane_wdata;
                            strobe_reg    <= lane_strobe;
                            write_reg     <= req_write;
`ifdef CPU_BUS_TIMEOUT_EN
                            wait_count_reg <= '0;
`endif
                        end else begin
                            // Rejected request: answer straight away, no bus cycle.
                            state_reg     <= ST_RESP;
                            rsp_valid_reg <= 1'b1;
                            rsp_err_reg   <= 1'b1;
                            rsp_rdata_reg <= '0;
                        end
                    end
                end
                ST_ACCESS: begin
                    // bus_ready wins over a timeout landing in the same cycle.
                    if (bus_ready) begin
                        state_reg     <= ST_RESP;
                        bus_valid_reg <= 1'b0;
                        rsp_valid_reg <= 1'b1;
                        rsp_err_reg   <= 1'b0;
                        rsp_rdata_reg <= write_reg ? '0 : lane_rdata;
                    end
`ifdef CPU_BUS_TIMEOUT_EN
                    else if (wait_count_reg == TIMEOUT_LAST) begin
                        state_reg     <= ST_RESP;
                        bus_valid_reg <= 1'b0;
                        rsp_valid_reg <= 1'b1;
                        rsp_err_reg   <= 1'b1;
                        rsp_rdata_reg <= '0;
                    end else begin
                        wait_count_reg <= wait_count_reg + 1'b1;
                    end
`endif
                end
                ST_RESP: begin
                    // Doubles as the mandatory idle cycle between bus cycles.
                    state_reg     <= ST_IDLE;
                    req_ready_reg <= 1'b1;
                end
                default: begin
                    state_reg     <= ST_IDLE;
                    bus_valid_reg <= 1'b0;
                    req_ready_reg <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready      = req_ready_reg;
    assign rsp_valid      = rsp_valid_reg;
    assign rsp_rdata      = rsp_rdata_reg;
    assign rsp_err        = rsp_err_reg;
    assign address        = address_reg;
    assign dataOut        = data_out_reg;
    assign busWriteEnable = write_reg;
    assign bus_strobe     = strobe_reg;
    assign bus_valid      = bus_valid_reg;

endmodule

// File: tb/tb_cpu_bus_unit.sv
// Self-checking bench for cpu_bus_unit (32-bit data, TIMEOUT_CYCLES = 4).
// Directed cases plus random requests checked against an arithmetic model.
module tb_cpu_bus_unit;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [1:0]    req_size;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic [AW-1:0] address;
    logic [DW-1:0] dataOut;
    logic [DW-1:0] dataIn;
    logic          busWriteEnable;
    logic [DW/8-1:0] bus_strobe;
    logic          bus_valid;
    logic          bus_ready;

    int checks = 0;
    int errors = 0;
    int txn_no = 0;

    cpu_bus_unit #(
        .DATA_WIDTH     (DW),
        .ADDR_WIDTH     (AW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_write      (req_write),
        .req_size       (req_size),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .rsp_valid      (rsp_valid),
        .rsp_rdata      (rsp_rdata),
        .rsp_err        (rsp_err),
        .address        (address),
        .dataOut        (dataOut),
        .dataIn         (dataIn),
        .busWriteEnable (busWriteEnable),
        .bus_strobe     (bus_strobe),
        .bus_valid      (bus_valid),
        .bus_ready      (bus_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Model: byte count of a size and legality of a request.
    function automatic int m_bytes(input logic [1:0] sz);
        return 1 << sz;
    endfunction

    function automatic logic m_legal(input logic [1:0] sz, input logic [31:0] a);
        return (sz != 2'd3) && ((a % m_bytes(sz)) == 0);
    endfunction

    // Model: strobe is a run of "size" ones starting at the byte offset.
    function automatic logic [3:0] m_strobe(input logic [1:0] sz, input logic [31:0] a);
        int n;
        n = m_bytes(sz);
        return 4'(((1 << n) - 1) << (a % 4));
    endfunction

    // Model: replicating a 1/2/4-byte value equals multiplying by 0x01010101/0x00010001/1.
    function automatic logic [31:0] m_wdata(input logic [1:0] sz, input logic [31:0] w);
        logic [31:0] r;
        case (sz)
            2'd0:    r = (w & 32'h0000_00FF) * 32'h0101_0101;
            2'd1:    r = (w & 32'h0000_FFFF) * 32'h0001_0001;
            default: r = w;
        endcase
        return r;
    endfunction

    // Model: read data is the bus word shifted down by the offset and masked to the size.
    function automatic logic [31:0] m_rdata(input logic [1:0] sz, input logic [31:0] a,
                                            input logic [31:0] din);
        logic [63:0] mask;
        mask = (64'd1 << (8 * m_bytes(sz))) - 64'd1;
        return 32'((64'(din) >> (8 * (a % 4))) & mask);
    endfunction

    // One core request from the negedge where the unit is idle through to its response.
    task automatic run_txn(input logic wr, input logic [1:0] sz, input logic [31:0] a,
                           input logic [31:0] wd, input int waits, input logic [31:0] din);
        logic        legal;
        logic [31:0] e_addr;
        logic [31:0] e_rd;
        legal  = m_legal(sz, a);
        e_addr = a & 32'hFFFF_FFFC;
        e_rd   = wr ? 32'h0 : m_rdata(sz, a, din);
        check("req_ready_idle", req_ready, 1);
        req_valid = 1'b1;
        req_write = wr;
        req_size  = sz;
        req_addr  = a;
        req_wdata = wd;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        req_wdata = $urandom;
        req_addr  = $urandom;
        if (!legal) begin
            check("illegal_rsp_valid", rsp_valid, 1);
            check("illegal_rsp_err", rsp_err, 1);
            check("illegal_rsp_rdata", rsp_rdata, 0);
            check("illegal_no_bus", bus_valid, 0);
            check("illegal_not_ready", req_ready, 0);
            @(negedge clk);
            check("illegal_rsp_one_cycle", rsp_valid, 0);
            check("illegal_no_bus_after", bus_valid, 0);
        end else begin
            for (int k = 0; k <= waits; k++) begin
                check("bus_valid", bus_valid, 1);
                check("bus_address", address, e_addr);
                check("bus_strobe", bus_strobe, m_strobe(sz, a));
                check("bus_we", busWriteEnable, wr);
                check("rsp_valid_wait", rsp_valid, 0);
                check("req_ready_busy", req_ready, 0);
                if (wr) check("bus_dataout", dataOut, m_wdata(sz, wd));
                bus_ready = (k == waits);
                dataIn    = (k == waits) ? din : $urandom;
                @(negedge clk);
            end
            bus_ready = 1'b0;
            dataIn    = $urandom;
            check("rsp_valid", rsp_valid, 1);
            check("rsp_err", rsp_err, 0);
            check("rsp_rdata", rsp_rdata, e_rd);
            check("bus_valid_resp", bus_valid, 0);
            @(negedge clk);
            check("rsp_one_cycle", rsp_valid, 0);
            check("bus_idle_gap", bus_valid, 0);
        end
        $display("txn %0d: %s size=%0d addr=%08h wdata=%08h waits=%0d legal=%0d exp_rdata=%08h got_rdata=%08h err=%0d",
                 txn_no, wr ? "WR" : "RD", sz, a, wd, waits, legal, e_rd, rsp_rdata, rsp_err);
        txn_no++;
    endtask

    initial begin
        reset     = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_size  = 2'd0;
        req_addr  = '0;
        req_wdata = '0;
        dataIn    = '0;
        bus_ready = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_req_ready", req_ready, 0);
        check("reset_bus_valid", bus_valid, 0);
        check("reset_rsp_valid", rsp_valid, 0);
        check("reset_address", address, 0);
        check("reset_strobe", bus_strobe, 0);
        check("reset_dataout", dataOut, 0);
        reset = 1'b1;
        @(negedge clk);
        check("release_req_ready", req_ready, 1);

        // Directed cases
        run_txn(1'b0, 2'd2, 32'h0000_0100, 32'h0, 0, 32'hDEAD_BEEF);
        run_txn(1'b1, 2'd0, 32'h0000_0103, 32'h0000_00AB, 0, $urandom);
        run_txn(1'b0, 2'd1, 32'h0000_0101, 32'h0, 0, $urandom);
        run_txn(1'b0, 2'd1, 32'h0000_0102, 32'h0, 3, 32'h1234_5678);
        run_txn(1'b1, 2'd1, 32'h0000_0206, 32'hCAFE_5A5A, 1, $urandom);
        run_txn(1'b0, 2'd3, 32'h0000_0300, 32'h0, 0, $urandom);
        run_txn(1'b0, 2'd0, 32'h0000_0401, 32'h0, 2, 32'h89AB_CDEF);

        // Bus never answers
        check("stall_req_ready", req_ready, 1);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_size  = 2'd2;
        req_addr  = 32'h0000_0200;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
`ifdef CPU_BUS_TIMEOUT_EN
        for (int k = 0; k < TO; k++) begin
            check("timeout_bus_valid", bus_valid, 1);
            check("timeout_no_rsp", rsp_valid, 0);
            dataIn = $urandom;
            @(negedge clk);
        end
        check("timeout_rsp_valid", rsp_valid, 1);
        check("timeout_rsp_err", rsp_err, 1);
        check("timeout_rsp_rdata", rsp_rdata, 0);
        check("timeout_bus_dropped", bus_valid, 0);
        @(negedge clk);
        check("timeout_rsp_one_cycle", rsp_valid, 0);
`else
        for (int k = 0; k < 20; k++) begin
            check("stall_bus_valid", bus_valid, 1);
            check("stall_no_rsp", rsp_valid, 0);
            dataIn = $urandom;
            @(negedge clk);
        end
        bus_ready = 1'b1;
        dataIn    = 32'h0BAD_F00D;
        @(negedge clk);
        bus_ready = 1'b0;
        check("stall_rsp_valid", rsp_valid, 1);
        check("stall_rsp_err", rsp_err, 0);
        check("stall_rsp_rdata", rsp_rdata, 32'h0BAD_F00D);
        @(negedge clk);
`endif
        $display("txn %0d: RD stalled bus cycle at addr=00000200", txn_no);
        txn_no++;

        // Reset during a bus cycle
        check("abort_req_ready", req_ready, 1);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_size  = 2'd2;
        req_addr  = 32'h0000_0500;
        req_wdata = 32'h1111_2222;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check("abort_bus_valid_before", bus_valid, 1);
        reset = 1'b0;
        @(negedge clk);
        check("abort_bus_valid", bus_valid, 0);
        check("abort_rsp_valid", rsp_valid, 0);
        check("abort_req_ready_low", req_ready, 0);
        check("abort_we", busWriteEnable, 0);
        reset = 1'b1;
        @(negedge clk);
        check("abort_req_ready_high", req_ready, 1);
        check("abort_no_rsp", rsp_valid, 0);
        check("abort_bus_idle", bus_valid, 0);
        $display("txn %0d: WR aborted by reset at addr=00000500", txn_no);
        txn_no++;

        // Random requests
        for (int t = 0; t < 30; t++) begin
            logic [1:0]  sz;
            logic [31:0] a;
            sz = 2'($urandom_range(0, 3));
            a  = $urandom;
            if ($urandom_range(0, 3) != 0)
                a = a & ~(32'(m_bytes(sz)) - 32'd1);
            run_txn(1'($urandom_range(0, 1)), sz, a, $urandom, $urandom_range(0, 3), $urandom);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cpu_bus_unit.md
CPU_BUS_UNIT -- requirements
Module: cpu_bus_unit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: bus data width, legal values 32 or 64.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32: byte-address width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 255: maximum bus wait cycles, range 1..65535.
REQ-004 SHALL have port clk, input, 1: the single clock; all logic on the rising edge.
REQ-005 SHALL have port reset, input, 1: synchronous, active-low reset.
REQ-006 SHALL have core-side ports: req_valid in 1; req_ready out 1; req_write in 1; req_size in 2 (0 byte, 1 half, 2 word, 3 double); req_addr in ADDR_WIDTH; req_wdata in DATA_WIDTH.
REQ-007 SHALL have response ports: rsp_valid out 1; rsp_rdata out DATA_WIDTH; rsp_err out 1.
REQ-008 SHALL have bus-side ports: address out ADDR_WIDTH; dataOut out DATA_WIDTH; dataIn in DATA_WIDTH; busWriteEnable out 1 (1 write, 0 read); bus_strobe out DATA_WIDTH/8; bus_valid out 1; bus_ready in 1.

Function
REQ-009 SHALL implement FSM states IDLE, ACCESS, RESP; IDLE->ACCESS on accepted legal request, IDLE->RESP on accepted illegal request, ACCESS->RESP on bus_ready or timeout, RESP->IDLE unconditionally.
REQ-010 SHALL assert req_ready only in IDLE; a request is accepted when req_valid and req_ready are both high at a clock edge.
REQ-011 SHALL treat as illegal: address not aligned to the size; req_size 3 when DATA_WIDTH is 32.
REQ-012 SHALL, for illegal requests, issue no bus cycle and give rsp_valid with rsp_err 1 and rsp_rdata 0 in the cycle after acceptance.
REQ-013 SHALL, in ACCESS, drive address as req_addr with low log2(DATA_WIDTH/8) bits cleared, hold bus_valid, busWriteEnable, bus_strobe and dataOut constant until bus_ready is sampled high.
REQ-014 SHALL derive bus_strobe from size and low address bits (e.g. 32-bit, half at offset 2 gives 4'b1100) and replicate write data onto all selected lanes.
REQ-015 SHALL, on read completion, right-shift the selected lanes to bit 0 and zero-extend into rsp_rdata; on write completion rsp_rdata is 0.
REQ-016 SHALL give minimum latency: accepted at edge N, bus_valid high from N+1, bus_ready high in that cycle, rsp_valid high for exactly one cycle after edge N+2.
REQ-017 SHALL keep bus_valid low in IDLE and RESP; no back-to-back bus cycles (one idle cycle minimum between them).
REQ-018 SHALL latch dataIn only in the cycle bus_ready is high; dataIn at other times is ignored.

Reset
REQ-019 SHALL, when reset is low at a clock edge, enter IDLE and zero all outputs except req_ready, which is 1 from the first edge after reset releases.
REQ-020 SHALL abort an in-flight bus cycle on reset with no response generated; bus_valid low after that edge.

Configuration
REQ-021 SHALL, with macro CPU_BUS_TIMEOUT_EN defined, count ACCESS cycles without bus_ready and, on the TIMEOUT_CYCLES-th such cycle, drop bus_valid and go to RESP with rsp_err 1, rsp_rdata 0.
REQ-022 SHALL, without CPU_BUS_TIMEOUT_EN, wait in ACCESS indefinitely; rsp_err then only reports illegal requests; no counter logic present.
REQ-023 SHALL treat bus_ready arriving in the same cycle as the timeout as a successful completion (rsp_err 0).

Structure
REQ-024 SHALL place the size encoding, the FSM state type and the alignment-check function in shared package cpu_bus_pkg.
REQ-025 SHALL put strobe generation, write-lane replication and read-lane extraction in one combinational sub-module, bus_lane_align.

Verification
REQ-026 Read word 0x100, bus_ready immediate, dataIn 0xDEADBEEF -> rsp_valid 2 cycles after accept, rsp_rdata 0xDEADBEEF, rsp_err 0, bus_strobe 4'b1111.
REQ-027 Write byte 0x103 data 0x000000AB -> address 0x100, bus_strobe 4'b1000, dataOut 0xABABABAB, busWriteEnable 1.
REQ-028 Read half 0x101 -> no bus_valid ever, rsp_err 1, rsp_rdata 0 one cycle after accept.
REQ-029 Read half 0x102, bus_ready after 3 wait cycles, dataIn 0x12345678 -> signals stable during wait, rsp_rdata 0x00001234.
REQ-030 CPU_BUS_TIMEOUT_EN, TIMEOUT_CYCLES 4, bus_ready never -> bus_valid for 4 cycles, then rsp_err 1; without the macro bus_valid stays high.
REQ-031 Reset low during ACCESS -> next edge bus_valid 0, rsp_valid 0, req_ready 1 after release.
